// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Brief    : Time-multiplexed N-digit 7-segment driver with BCD decode,
//            leading-zero blanking, per-digit decimal point and blink.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int DIV          = 50000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lzb_en,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int c_PW = (DIV > 1)          ? $clog2(DIV)          : 1;
    localparam int c_IW = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
    localparam int c_BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [c_PW-1:0]       r_presc;
    logic [c_IW-1:0]       r_idx;
    logic [c_BW-1:0]       r_bcnt;
    logic                  r_phase;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [DIGITS-1:0]     r_dp;
    logic [DIGITS-1:0]     r_blink;
    logic                  r_lzb;
    logic [7:0]            r_seg;
    logic [DIGITS-1:0]     r_an;
    logic                  r_frame_tick;

    logic                  w_slot_tick;
    logic                  w_last;
    logic                  w_frame_start;
    logic                  w_bcnt_wrap;
    logic [c_IW-1:0]       w_idx_next;
    logic                  w_phase_next;
    logic [4*DIGITS-1:0]   w_bcd_v;
    logic [DIGITS-1:0]     w_dp_v;
    logic [DIGITS-1:0]     w_blink_v;
    logic                  w_lzb_v;
    logic [DIGITS:0]       w_lead;
    logic [3:0]            w_code;
    logic [6:0]            w_hi;
    logic                  w_blank_lz;
    logic [7:0]            w_seg_next;
    logic [DIGITS-1:0]     w_an_next;

    assign w_slot_tick   = (r_presc == c_PW'(DIV - 1));
    assign w_last        = (r_idx == c_IW'(DIGITS - 1));
    assign w_frame_start = w_slot_tick && w_last;
    assign w_bcnt_wrap   = (r_bcnt == c_BW'(BLINK_FRAMES - 1));

    // The output registers load on the same edge the index/snapshot change,
    // so everything they see is the "next" view of the state.
    assign w_idx_next   = w_slot_tick ? (w_last ? '0 : r_idx + c_IW'(1)) : r_idx;
    assign w_phase_next = (w_frame_start && w_bcnt_wrap) ? ~r_phase : r_phase;
    assign w_bcd_v      = w_frame_start ? bcd_in     : r_bcd;
    assign w_dp_v       = w_frame_start ? dp_in      : r_dp;
    assign w_blink_v    = w_frame_start ? blink_mask : r_blink;
    assign w_lzb_v      = w_frame_start ? lzb_en     : r_lzb;

    // w_lead[i]: digit i and every digit above it are zero.
    always_comb begin
        w_lead         = '0;
        w_lead[DIGITS] = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_lead[i] = w_lead[i+1] && (w_bcd_v[4*i +: 4] == 4'd0);
        end
    end

    assign w_code     = w_bcd_v[4*w_idx_next +: 4];
    assign w_blank_lz = w_lzb_v && (w_idx_next != '0) && w_lead[w_idx_next];

    always_comb begin
        w_hi = 7'h00;
        case (w_code)
            4'd0:    w_hi = 7'h7E;
            4'd1:    w_hi = 7'h30;
            4'd2:    w_hi = 7'h6D;
            4'd3:    w_hi = 7'h79;
            4'd4:    w_hi = 7'h33;
            4'd5:    w_hi = 7'h5B;
            4'd6:    w_hi = 7'h5F;
            4'd7:    w_hi = 7'h70;
            4'd8:    w_hi = 7'h7F;
            4'd9:    w_hi = 7'h7B;
            4'd11:   w_hi = 7'h01;
            default: w_hi = 7'h00;
        endcase
    end

    always_comb begin
        w_seg_next = {~(w_blank_lz ? 7'h00 : w_hi), ~w_dp_v[w_idx_next]};
        if (w_phase_next && w_blink_v[w_idx_next]) begin
            w_seg_next = 8'hFF;
        end
        w_an_next = ~(DIGITS'(1) << w_idx_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_bcnt       <= '0;
            r_phase      <= 1'b0;
            r_bcd        <= '0;
            r_dp         <= '0;
            r_blink      <= '0;
            r_lzb        <= 1'b0;
            r_seg        <= 8'hFF;
            r_an         <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_presc      <= w_slot_tick ? '0 : r_presc + c_PW'(1);
            r_idx        <= w_idx_next;
            r_phase      <= w_phase_next;
            r_frame_tick <= w_frame_start;
            if (w_frame_start) begin
                r_bcnt  <= w_bcnt_wrap ? '0 : r_bcnt + c_BW'(1);
                r_bcd   <= bcd_in;
                r_dp    <= dp_in;
                r_blink <= blink_mask;
                r_lzb   <= lzb_en;
            end
            if (en) begin
                r_seg <= w_seg_next;
                r_an  <= w_an_next;
            end else begin
                r_seg <= 8'hFF;
                r_an  <= '1;
            end
        end
    end

    assign seg        = r_seg;
    assign an         = r_an;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Brief    : Directed scoreboard bench for seg7_scan_driver (4 digits, DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [15:0] bcd_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  blink_mask = 4'h0;
    logic        lzb_en = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;
    logic [11:0] sb_q[$];

    seg7_scan_driver #(.DIGITS(4), .DIV(4), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .blink_mask (blink_mask),
        .lzb_en     (lzb_en),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bounded wait: returns on the negedge where frame_tick is high.
    task automatic wait_tick(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (frame_tick) found = 1'b1;
        end
        chk({tag, "_tick_timeout"}, {31'd0, found}, 32'd1);
    endtask

    task automatic push_frame(input logic [7:0] s3, input logic [7:0] s2,
                              input logic [7:0] s1, input logic [7:0] s0);
        sb_q.push_back({4'b1110, s0});
        sb_q.push_back({4'b1101, s1});
        sb_q.push_back({4'b1011, s2});
        sb_q.push_back({4'b0111, s3});
    endtask

    // Check one full frame against the queued expectations; optionally
    // change bcd_in while digit 2 is on screen.
    task automatic check_frame(input string tag, input logic chg, input logic [15:0] nbcd);
        logic [11:0] e;
        wait_tick(tag);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (4) @(negedge clk);
            if (chg && k == 2) bcd_in = nbcd;
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 12'hxxx;
            chk($sformatf("%s_d%0d", tag, k), {20'd0, an, seg}, {20'd0, e});
        end
    endtask

    initial begin
        int n;
        bcd_in = 16'h1234; dp_in = 4'b0100; lzb_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_seg", {24'd0, seg}, 32'hFF);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_ft", {31'd0, frame_tick}, 32'd0);
        rst = 1'b0;

        // Frame period and single-cycle tick
        wait_tick("per0");
        @(negedge clk);
        chk("ft_width", {31'd0, frame_tick}, 32'd0);
        n = 1;
        while (!frame_tick && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ft_period", n, 32'd16);

        push_frame(8'h9F, 8'h24, 8'h0D, 8'h99);
        check_frame("dec1234", 1'b0, 16'h0);

        bcd_in = 16'h0007; lzb_en = 1'b1; dp_in = 4'b0000;
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);   // frame still from old snapshot? replaced below
        sb_q.delete();
        wait_tick("lz_sync");
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'h1F);
        check_frame("lz7", 1'b0, 16'h0);
        bcd_in = 16'h0000;
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'h03);
        check_frame("lz0", 1'b0, 16'h0);
        bcd_in = 16'h00B0;
        push_frame(8'hFF, 8'hFF, 8'hFD, 8'h03);
        check_frame("lzB0", 1'b0, 16'h0);
        bcd_in = 16'h0000; dp_in = 4'b0100;
        push_frame(8'hFF, 8'hFE, 8'hFF, 8'h03);
        check_frame("lz_dp", 1'b0, 16'h0);

        // Blink: reset puts phase/frame counter at a known point.
        bcd_in = 16'h5959; blink_mask = 4'b0011; lzb_en = 1'b0; dp_in = 4'b0000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_frame(8'h49, 8'h09, 8'h49, 8'h09);
        check_frame("blk_f1", 1'b0, 16'h0);
        push_frame(8'h49, 8'h09, 8'hFF, 8'hFF);
        check_frame("blk_f2", 1'b0, 16'h0);
        push_frame(8'h49, 8'h09, 8'hFF, 8'hFF);
        check_frame("blk_f3", 1'b0, 16'h0);
        push_frame(8'h49, 8'h09, 8'h49, 8'h09);
        check_frame("blk_f4", 1'b0, 16'h0);
        push_frame(8'h49, 8'h09, 8'h49, 8'h09);
        check_frame("blk_f5", 1'b0, 16'h0);

        // Snapshot does not tear a frame.
        blink_mask = 4'b0000; bcd_in = 16'h1111;
        wait_tick("tear_sync");
        push_frame(8'h9F, 8'h9F, 8'h9F, 8'h9F);
        check_frame("tear_a", 1'b0, 16'h0);
        push_frame(8'h9F, 8'h9F, 8'h9F, 8'h9F);
        check_frame("tear_b", 1'b1, 16'h2222);
        push_frame(8'h25, 8'h25, 8'h25, 8'h25);
        check_frame("tear_c", 1'b0, 16'h0);

        // Reset for one cycle while digit 3 is on screen.
        wait_tick("r6_sync");
        repeat (12) @(negedge clk);
        chk("r6_pre_an", {28'd0, an}, 32'h7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("r6_seg", {24'd0, seg}, 32'hFF);
        chk("r6_an", {28'd0, an}, 32'hF);
        chk("r6_ft", {31'd0, frame_tick}, 32'd0);
        @(negedge clk);
        chk("r6_restart_an", {28'd0, an}, 32'hE);
        chk("r6_restart_seg", {24'd0, seg}, 32'h03);

        // Display disabled for one frame; scanning keeps going.
        wait_tick("en_sync");
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat (4) @(negedge clk);
            chk($sformatf("en0_an%0d", k), {20'd0, an, seg}, 32'hFFF);
        end
        chk("en0_ft", {31'd0, frame_tick}, 32'd1);
        en = 1'b1;
        push_frame(8'h25, 8'h25, 8'h25, 8'h25);
        check_frame("en1", 1'b0, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
